// File: rtl/regfile_write_queue.sv
// Register file write queue: in-order FIFO of register writes that feeds the
// register file write port one write per clock, with combinational
// forwarding of the youngest pending value to two read-address probes.

// Forwarding lookup for one probe. The candidates are ordered oldest first,
// so the last match found is the youngest pending value for that address.
module regfile_wq_probe #(
  parameter int N      = 5,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic                        en,
  input  logic [ADDR_W-1:0]           probe,
  input  logic [N-1:0]                cvld,
  input  logic [N-1:0][ADDR_W-1:0]    caddr,
  input  logic [N-1:0][DATA_W-1:0]    cdata,
  output logic                        hit,
  output logic [DATA_W-1:0]           hdata
);
  // Scan oldest to youngest; a later match overrides an earlier one.
  always_comb begin
    hit   = 1'b0;
    hdata = '0;
    for (int i = 0; i < N; i++) begin
      if (en && cvld[i] && (caddr[i] == probe)) begin
        hit   = 1'b1;
        hdata = cdata[i];
      end
    end
  end
endmodule

module regfile_write_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic                       CLK,
  input  logic                       Reset,
  input  logic                       InValid,
  output logic                       InReady,
  input  logic [ADDR_W-1:0]          InAddress,
  input  logic [DATA_W-1:0]          InData,
  input  logic                       Hold,
  output logic                       WriteEnable,
  output logic [ADDR_W-1:0]          WriteAddress,
  output logic [DATA_W-1:0]          WriteData,
  input  logic [ADDR_W-1:0]          ProbeAddress1,
  input  logic [ADDR_W-1:0]          ProbeAddress2,
  output logic                       Hit1,
  output logic                       Hit2,
  output logic [DATA_W-1:0]          HitData1,
  output logic [DATA_W-1:0]          HitData2,
  output logic [$clog2(DEPTH):0]     Count
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int NCAND  = DEPTH + 1;
  localparam int NPROBE = 2;

  logic [DEPTH-1:0][ADDR_W-1:0] mem_addr;
  logic [DEPTH-1:0][DATA_W-1:0] mem_data;
  logic [PTR_W-1:0]             rd_ptr, wr_ptr;
  logic                         push, pop;

  // A pop never frees a slot for a same-cycle push when full.
  assign InReady = !Reset && (Count < CNT_W'(DEPTH));
  assign push    = InValid && InReady;
  assign pop     = !Hold && (Count != '0);

  // FIFO state and the registered write port; reset wins over everything.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      Count        <= '0;
      WriteEnable  <= 1'b0;
      WriteAddress <= '0;
      WriteData    <= '0;
    end else begin
      if (push) begin
        mem_addr[wr_ptr] <= InAddress;
        mem_data[wr_ptr] <= InData;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        WriteAddress <= mem_addr[rd_ptr];
        WriteData    <= mem_data[rd_ptr];
        rd_ptr       <= rd_ptr + 1'b1;
      end
      WriteEnable <= pop;
      Count       <= Count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Candidate list ordered oldest first: the output register (committing at
  // the next edge) in slot 0, then queue entries from head to tail.
  logic [NCAND-1:0]             cvld;
  logic [NCAND-1:0][ADDR_W-1:0] caddr;
  logic [NCAND-1:0][DATA_W-1:0] cdata;

  // Rotate the circular buffer into age order starting at the read pointer.
  always_comb begin
    cvld     = '0;
    caddr    = '0;
    cdata    = '0;
    cvld[0]  = WriteEnable;
    caddr[0] = WriteAddress;
    cdata[0] = WriteData;
    for (int i = 0; i < DEPTH; i++) begin
      cvld[i+1]  = CNT_W'(i) < Count;
      caddr[i+1] = mem_addr[rd_ptr + PTR_W'(i)];
      cdata[i+1] = mem_data[rd_ptr + PTR_W'(i)];
    end
  end

  logic [NPROBE-1:0][ADDR_W-1:0] probe;
  logic [NPROBE-1:0]             hit;
  logic [NPROBE-1:0][DATA_W-1:0] hdata;

  assign probe = {ProbeAddress2, ProbeAddress1};

  generate
    for (genvar g = 0; g < NPROBE; g++) begin : g_probe
      regfile_wq_probe #(.N(NCAND), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_probe (
        .en    (!Reset),
        .probe (probe[g]),
        .cvld  (cvld),
        .caddr (caddr),
        .cdata (cdata),
        .hit   (hit[g]),
        .hdata (hdata[g])
      );
    end
  endgenerate

  assign Hit1     = hit[0];
  assign Hit2     = hit[1];
  assign HitData1 = hdata[0];
  assign HitData2 = hdata[1];
endmodule

// File: tb/tb_regfile_write_queue.sv
// Self-checking bench for regfile_write_queue: a reference model of the queue
// and output register, plus a scoreboard of expected writes that is drained
// whenever the DUT raises WriteEnable.
module tb_regfile_write_queue;
  localparam int DEPTH = 4;

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
  } ent_t;

  logic       CLK, Reset, InValid, InReady, Hold;
  logic [3:0] InAddress, ProbeAddress1, ProbeAddress2, WriteAddress;
  logic [7:0] InData, WriteData, HitData1, HitData2;
  logic       WriteEnable, Hit1, Hit2;
  logic [2:0] Count;

  int checks = 0;
  int errors = 0;

  ent_t mq[$];   // model queue contents
  ent_t wq[$];   // scoreboard: writes expected on the port
  logic       m_we;
  logic [3:0] m_wa;
  logic [7:0] m_wd;

  regfile_write_queue #(.DEPTH(DEPTH), .ADDR_W(4), .DATA_W(8)) dut (
    .CLK(CLK), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .InAddress(InAddress), .InData(InData), .Hold(Hold),
    .WriteEnable(WriteEnable), .WriteAddress(WriteAddress), .WriteData(WriteData),
    .ProbeAddress1(ProbeAddress1), .ProbeAddress2(ProbeAddress2),
    .Hit1(Hit1), .Hit2(Hit2), .HitData1(HitData1), .HitData2(HitData2),
    .Count(Count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Youngest pending value for a probe: output register first, queue tail last.
  task automatic fwd(input logic [3:0] p, output logic h, output logic [7:0] d);
    h = 1'b0;
    d = '0;
    if (!Reset) begin
      if (m_we && m_wa == p) begin h = 1'b1; d = m_wd; end
      foreach (mq[i]) if (mq[i].a == p) begin h = 1'b1; d = mq[i].d; end
    end
  endtask

  task automatic check_outputs();
    logic h; logic [7:0] d; ent_t e;
    chk("count", 32'(Count), 32'(mq.size()));
    chk("in_ready", 32'(InReady), 32'(!Reset && mq.size() < DEPTH));
    chk("write_en", 32'(WriteEnable), 32'(m_we));
    chk("write_addr", 32'(WriteAddress), 32'(m_wa));
    chk("write_data", 32'(WriteData), 32'(m_wd));
    fwd(ProbeAddress1, h, d);
    chk("hit1", 32'(Hit1), 32'(h));
    chk("hitdata1", 32'(HitData1), 32'(d));
    fwd(ProbeAddress2, h, d);
    chk("hit2", 32'(Hit2), 32'(h));
    chk("hitdata2", 32'(HitData2), 32'(d));
    if (WriteEnable) begin
      if (wq.size() == 0) chk("sb_spurious_write", 32'(1), 32'(0));
      else begin
        e = wq.pop_front();
        chk("sb_addr", 32'(WriteAddress), 32'(e.a));
        chk("sb_data", 32'(WriteData), 32'(e.d));
      end
    end else if (wq.size() != 0) begin
      chk("sb_missing_write", 32'(0), 32'(1));
      wq.delete();
    end
  endtask

  // One clock: drive inputs after the falling edge, update the model at the
  // rising edge, check at the next falling edge.
  task automatic step(input logic v, input logic [3:0] a, input logic [7:0] d, input logic h);
    logic acc, pp; ent_t e;
    InValid = v; InAddress = a; InData = d; Hold = h;
    acc = v && !Reset && (mq.size() < DEPTH);
    pp  = !Reset && !h && (mq.size() > 0);
    @(posedge CLK);
    if (Reset) begin
      mq.delete();
      m_we = 1'b0; m_wa = '0; m_wd = '0;
    end else begin
      if (pp) begin
        e = mq.pop_front();
        m_we = 1'b1; m_wa = e.a; m_wd = e.d;
        wq.push_back(e);
      end else m_we = 1'b0;
      if (acc) mq.push_back('{a: a, d: d});
    end
    @(negedge CLK);
    check_outputs();
  endtask

  task automatic idle(input int n, input logic h);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 8'h00, h);
  endtask

  initial begin
    Reset = 1'b1; InValid = 0; InAddress = 0; InData = 0; Hold = 0;
    ProbeAddress1 = 0; ProbeAddress2 = 0;
    m_we = 0; m_wa = 0; m_wd = 0;
    @(negedge CLK);
    // push presented during reset is dropped
    step(1'b1, 4'h9, 8'hEE, 1'b0);
    step(1'b1, 4'h9, 8'hEE, 1'b0);
    chk("rst_count", 32'(Count), 32'(0));
    chk("rst_ready", 32'(InReady), 32'(0));
    Reset = 1'b0;
    idle(1, 1'b0);

    // single write latency
    ProbeAddress1 = 4'd3;
    step(1'b1, 4'd3, 8'h5A, 1'b0);
    chk("lat_count1", 32'(Count), 32'(1));
    chk("lat_we0", 32'(WriteEnable), 32'(0));
    idle(1, 1'b0);
    chk("lat_we1", 32'(WriteEnable), 32'(1));
    chk("lat_addr", 32'(WriteAddress), 32'(3));
    chk("lat_data", 32'(WriteData), 32'(8'h5A));
    chk("lat_count0", 32'(Count), 32'(0));
    idle(1, 1'b0);
    chk("lat_we_once", 32'(WriteEnable), 32'(0));

    // fill under hold, fifth push ignored, then drain in order
    for (int i = 1; i <= 4; i++) step(1'b1, 4'(i), 8'(i * 17), 1'b1);
    chk("full_count", 32'(Count), 32'(4));
    chk("full_ready", 32'(InReady), 32'(0));
    step(1'b1, 4'hF, 8'hFF, 1'b1);
    chk("full_count_kept", 32'(Count), 32'(4));
    idle(6, 1'b0);

    // duplicate address forwarding, youngest wins
    ProbeAddress1 = 4'd7; ProbeAddress2 = 4'd8;
    step(1'b1, 4'd7, 8'hA0, 1'b1);
    step(1'b1, 4'd7, 8'hB0, 1'b1);
    chk("dup_hit1", 32'(Hit1), 32'(1));
    chk("dup_data1", 32'(HitData1), 32'(8'hB0));
    chk("dup_hit2", 32'(Hit2), 32'(0));
    chk("dup_data2", 32'(HitData2), 32'(0));
    idle(4, 1'b0);

    // streaming across pointer wrap
    step(1'b1, 4'd0, 8'h30, 1'b0);
    for (int i = 1; i < 10; i++) begin
      step(1'b1, 4'(i), 8'(8'h30 + i), 1'b0);
      chk("stream_count", 32'(Count), 32'(1));
      chk("stream_we", 32'(WriteEnable), 32'(1));
    end
    idle(3, 1'b0);

    // reset mid-operation with 3 queued and a write on the port
    for (int i = 0; i < 4; i++) step(1'b1, 4'(i + 10), 8'(8'hC0 + i), 1'b1);
    idle(1, 1'b0);
    chk("pre_rst_count", 32'(Count), 32'(3));
    chk("pre_rst_we", 32'(WriteEnable), 32'(1));
    Reset = 1'b1;
    step(1'b1, 4'd2, 8'h22, 1'b0);
    chk("mid_rst_ready", 32'(InReady), 32'(0));
    chk("mid_rst_wa", 32'(WriteAddress), 32'(0));
    Reset = 1'b0;
    idle(4, 1'b0);

    // forwarding from queue over the output register, then from the register
    ProbeAddress1 = 4'd5; ProbeAddress2 = 4'd6;
    step(1'b1, 4'd5, 8'h77, 1'b1);
    step(1'b1, 4'd5, 8'h99, 1'b0);
    chk("fwd_reg_we", 32'(WriteEnable), 32'(1));
    chk("fwd_queue", 32'(HitData1), 32'(8'h99));
    idle(1, 1'b0);
    chk("fwd_outreg", 32'(HitData1), 32'(8'h99));
    chk("fwd_outreg_hit", 32'(Hit1), 32'(1));
    idle(2, 1'b0);

    // random traffic
    for (int i = 0; i < 200; i++) begin
      ProbeAddress1 = 4'($urandom_range(0, 15));
      ProbeAddress2 = 4'($urandom_range(0, 15));
      Reset = ($urandom_range(0, 40) == 0);
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom),
           ($urandom_range(0, 3) == 0));
    end
    Reset = 1'b0;
    idle(6, 1'b0);
    chk("sb_empty", 32'(wq.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
